// File: rtl/seg_mux_ctrl.sv
// Two-digit multiplexed seven-segment driver: BLANK1 -> DIG0 -> BLANK0 -> DIG1 schedule
// with registered segment/anode outputs and a registered 5-bit sum of the two inputs.
module seg_mux_ctrl #(
  parameter int DWELL_CYCLES = 20000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [4:0] led
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  typedef enum logic [1:0] {
    ST_BLANK1 = 2'd0,
    ST_DIG0   = 2'd1,
    ST_BLANK0 = 2'd2,
    ST_DIG1   = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [3:0]    r_d0, w_d0_next;
  logic [3:0]    r_d1, w_d1_next;
  logic [6:0]    r_seg, w_seg_next;
  logic [1:0]    r_an, w_an_next;
  logic [4:0]    r_led;
  logic          w_last;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    if (r_state == ST_DIG0 || r_state == ST_DIG1) w_last = (r_cnt == DWELL_LAST);
    else                                           w_last = (r_cnt == BLANK_LAST);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_ONE;
    w_d0_next    = r_d0;
    w_d1_next    = r_d1;
    w_an_next    = 2'b11;
    w_seg_next   = SEG_OFF;
    if (w_last) begin
      w_cnt_next = '0;
      case (r_state)
        ST_BLANK1: begin w_state_next = ST_DIG0;   w_d0_next = s0; end
        ST_DIG0:   w_state_next = ST_BLANK0;
        ST_BLANK0: begin w_state_next = ST_DIG1;   w_d1_next = s1; end
        default:   w_state_next = ST_BLANK1;
      endcase
    end
    // Outputs are computed from the next state so they switch on the same edge as it.
    case (w_state_next)
      ST_DIG0: begin w_an_next = 2'b10; w_seg_next = dec(w_d0_next); end
      ST_DIG1: begin w_an_next = 2'b01; w_seg_next = dec(w_d1_next); end
      default: begin w_an_next = 2'b11; w_seg_next = SEG_OFF;        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BLANK1;
      r_cnt   <= '0;
      r_d0    <= 4'd0;
      r_d1    <= 4'd0;
      r_an    <= 2'b11;
      r_seg   <= SEG_OFF;
      r_led   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_d0    <= w_d0_next;
      r_d1    <= w_d1_next;
      r_an    <= w_an_next;
      r_seg   <= w_seg_next;
      r_led   <= {1'b0, s0} + {1'b0, s1};
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign led = r_led;

endmodule

// File: doc/seg_mux_ctrl.md
# seg_mux_ctrl

Time-multiplexed display controller that lets one seven-segment decoder and one shared segment bus drive two common-anode digits. It alternates between the two 4-bit hex inputs using a fixed four-phase schedule with blanking gaps to prevent ghosting, and it presents a registered 5-bit sum of the two inputs on the LEDs. It sits between the DIP-switch inputs and the board-level display pins, in place of the single-digit decoder path used so far.

## Interface
Parameters:
- DWELL_CYCLES, 20000: clock cycles each digit is lit; must be ≥1.
- BLANK_CYCLES, 200: clock cycles both digits are dark between digits; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  reset. One clock; reset is synchronous and active-high.
- s0  in  4  hex value for digit 0.
- s1  in  4  hex value for digit 1.
- seg  out  7  shared segments {g,f,e,d,c,b,a}; active-low.
- an  out  2  digit anode enables; active-low; an[0] is digit 0, an[1] is digit 1.
- led  out  5  registered value of s0 + s1.

## Operation
- FSM states, in cyclic order: BLANK1 → DIG0 → BLANK0 → DIG1 → BLANK1.
- Each DIGx state lasts DWELL_CYCLES cycles. Each BLANKx state lasts BLANK_CYCLES cycles.
- A single down-counter or up-counter, sized with $clog2 of the larger parameter, times each state. On its terminal count it advances the state and reloads.
- Digit latching:
  - On the edge that enters DIG0, s0 is captured into d0.
  - On the edge that enters DIG1, s1 is captured into d1.
  - Input changes during a dwell have no effect until that digit's next entry.
- Outputs by state:
  - BLANK0 and BLANK1: an=2'b11, seg=7'b1111111.
  - DIG0: an=2'b10, seg=dec(d0).
  - DIG1: an=2'b01, seg=dec(d1).
- seg and an are driven from registers only. There is no combinational path from s0 or s1.
- dec() is the full hex table (0–F, active-low). Required codes:
  - 0=1000000, 1=1111001, 2=0100100, 8=0000000, A=0001000, F=0001110.
- led:
  - Each cycle, led is loaded with {1'b0,s0}+{1'b0,s1}, computed at 5 bits so it cannot overflow (max 30).
  - led is independent of the FSM.
- Invariant: an is never 2'b00 in any cycle, including reset and transitions.

## Timing
- Reset value of every output and register: state=BLANK1, counter=0, d0=d1=0, an=2'b11, seg=7'b1111111, led=0.
- After reset deasserts, BLANK1 occupies the first BLANK_CYCLES cycles. DIG0 begins on cycle BLANK_CYCLES.
- Full refresh period = 2·(DWELL_CYCLES+BLANK_CYCLES) cycles. The sequence is strictly periodic, with no drift.
- led latency is 1 cycle from a change in s0 or s1.
- seg and an change only on state transitions. Both switch on the same edge.
- Reset asserted in any state or at any counter value: on the next rising edge the block returns to reset values, and the sequence restarts from BLANK1.
- Boundary case DWELL_CYCLES=1 or BLANK_CYCLES=1: that state lasts exactly one cycle. No state is skipped.

## Test plan
Benches run with DWELL_CYCLES=4 and BLANK_CYCLES=2 (period 12). Cycle numbers count from the first edge with reset=0.
- Reset held 3 cycles with s0=5, s1=7 → during reset an=11, seg=1111111, led=00000. After release, led=01100 from cycle 1.
- s0=1, s1=2 held:
  - cycles 0–1: an=11.
  - cycles 2–5: an=10, seg=1111001.
  - cycles 6–7: an=11.
  - cycles 8–11: an=01, seg=0100100.
  - The pattern repeats at cycle 12.
- s0 changes from 1 to 8 at cycle 3 (mid-DIG0) → seg stays 1111001 through cycle 5. The next DIG0 (cycles 14–17) shows 0000000.
- s0=F, s1=F → led=11110 one cycle after application. Both digits show 0001110. s0=A shows 0001000.
- Reset pulsed for 1 cycle at cycle 9 (mid-DIG1) → at the next edge an=11, seg=1111111, led=0. The sequence restarts, with DIG0 arriving 2 cycles after release.
- Checker over all runs: flag an==2'b00, and flag any seg≠1111111 while an==2'b11.
